// File: rtl/sap1_pkg.sv
// Shared SAP-1 definitions: control-word bit positions and opcodes, common to
// the controller and the execution datapath.
package sap1_pkg;

  localparam int CW_W  = 12;

  localparam int CW_CP = 11;
  localparam int CW_EP = 10;
  localparam int CW_LM = 9;
  localparam int CW_CE = 8;
  localparam int CW_LI = 7;
  localparam int CW_EI = 6;
  localparam int CW_LA = 5;
  localparam int CW_EA = 4;
  localparam int CW_SU = 3;
  localparam int CW_EU = 2;
  localparam int CW_LB = 1;
  localparam int CW_LO = 0;

  localparam logic [3:0] OP_LDA = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_OUT = 4'b1110;
  localparam logic [3:0] OP_HLT = 4'b1111;

  // Control bits that put a source onto the W-bus
  localparam logic [CW_W-1:0] BUS_DRV_MASK =
    (CW_W'(1) << CW_EP) | (CW_W'(1) << CW_CE) | (CW_W'(1) << CW_EI) |
    (CW_W'(1) << CW_EA) | (CW_W'(1) << CW_EU);

  function automatic logic multi_driver(input logic [CW_W-1:0] cw);
    return $countones(cw & BUS_DRV_MASK) > 1;
  endfunction

endpackage

// File: rtl/sap1_alu.sv
// Combinational add/subtract unit; subtraction is two's-complement A + ~B + 1,
// so carry_o = 1 on subtract means no borrow occurred.
module sap1_alu #(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  input  logic              sub_i,
  output logic [DATA_W-1:0] sum_o,
  output logic              carry_o
);

  logic [DATA_W-1:0] b_sel;
  logic [DATA_W:0]   full;

  assign b_sel   = sub_i ? ~b_i : b_i;
  assign full    = {1'b0, a_i} + {1'b0, b_sel} + (DATA_W + 1)'(sub_i);
  assign sum_o   = full[DATA_W-1:0];
  assign carry_o = full[DATA_W];

endmodule

// File: rtl/sap1_datapath.sv
// SAP-1 execution datapath: W-bus, PC, MAR, 16x8 RAM, IR, A, B, ALU and output
// register, steered each T-state by the controller's control word.
module sap1_datapath
  import sap1_pkg::*;
#(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [CW_W-1:0]   cw,
  input  logic              halt,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [DATA_W-1:0] prog_data,
  output logic [3:0]        opcode,
  output logic [DATA_W-1:0] bus,
  output logic [ADDR_W-1:0] pc,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  output logic              carry,
  output logic              bus_err
);

  localparam int RAM_D = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem_q [RAM_D];

  logic [ADDR_W-1:0] pc_q,  pc_d;
  logic [ADDR_W-1:0] mar_q, mar_d;
  logic [DATA_W-1:0] ir_q,  ir_d;
  logic [DATA_W-1:0] a_q,   a_d;
  logic [DATA_W-1:0] b_q,   b_d;
  logic [DATA_W-1:0] out_q, out_d;
  logic              carry_q, carry_d;
  logic              out_valid_q, out_valid_d;
  logic              bus_err_q, bus_err_d;

  logic [DATA_W-1:0] bus_w;
  logic [DATA_W-1:0] alu_sum;
  logic              alu_carry;

  sap1_alu #(.DATA_W(DATA_W)) u_alu (
    .a_i     (a_q),
    .b_i     (b_q),
    .sub_i   (cw[CW_SU]),
    .sum_o   (alu_sum),
    .carry_o (alu_carry)
  );

  // Wired-OR bus: contention is visible as the OR of all enabled sources
  always_comb begin
    bus_w = '0;
    if (cw[CW_EP]) bus_w = bus_w | DATA_W'(pc_q);
    if (cw[CW_CE]) bus_w = bus_w | mem_q[mar_q];
    if (cw[CW_EI]) bus_w = bus_w | DATA_W'(ir_q[3:0]);
    if (cw[CW_EA]) bus_w = bus_w | a_q;
    if (cw[CW_EU]) bus_w = bus_w | alu_sum;
  end

  always_comb begin
    pc_d        = pc_q;
    mar_d       = mar_q;
    ir_d        = ir_q;
    a_d         = a_q;
    b_d         = b_q;
    out_d       = out_q;
    carry_d     = carry_q;
    out_valid_d = 1'b0;
    bus_err_d   = bus_err_q;
    if (!halt) begin
      if (cw[CW_CP]) pc_d  = pc_q + ADDR_W'(1);
      if (cw[CW_LM]) mar_d = bus_w[ADDR_W-1:0];
      if (cw[CW_LI]) ir_d  = bus_w;
      if (cw[CW_LA]) a_d   = bus_w;
      if (cw[CW_LA] && cw[CW_EU]) carry_d = alu_carry;
      if (cw[CW_LB]) b_d   = bus_w;
      if (cw[CW_LO]) out_d = bus_w;
      out_valid_d = cw[CW_LO];
      bus_err_d   = bus_err_q | multi_driver(cw);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q        <= '0;
      mar_q       <= '0;
      ir_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      out_q       <= '0;
      carry_q     <= 1'b0;
      out_valid_q <= 1'b0;
      bus_err_q   <= 1'b0;
    end else begin
      pc_q        <= pc_d;
      mar_q       <= mar_d;
      ir_q        <= ir_d;
      a_q         <= a_d;
      b_q         <= b_d;
      out_q       <= out_d;
      carry_q     <= carry_d;
      out_valid_q <= out_valid_d;
      bus_err_q   <= bus_err_d;
    end
  end

  // RAM is deliberately outside reset so a loaded program survives it
  always_ff @(posedge clk) begin
    if (halt && prog_we) mem_q[prog_addr] <= prog_data;
  end

  assign opcode    = ir_q[7:4];
  assign bus       = bus_w;
  assign pc        = pc_q;
  assign out_data  = out_q;
  assign out_valid = out_valid_q;
  assign carry     = carry_q;
  assign bus_err   = bus_err_q;

endmodule

// File: doc/sap1_datapath.md
Name: sap1_datapath

Overview:
- SAP-1 execution datapath that consumes the 12-bit control word from the controller each T-state.
- Returns the current opcode to the controller.
- Contains the W-bus, PC, MAR, 16x8 RAM, IR, accumulator A, register B, add/sub ALU and output register.
- Includes a halt-time program-load port and a sticky bus-contention error flag for bring-up and verification.

Parameters:
- ADDR_W, 4, RAM/PC/MAR address width (RAM depth = 2**ADDR_W).
- DATA_W, 8, W-bus, register and RAM word width.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset (asserted when 0).
- cw  in  12  control word, active-high, bit layout from sap1_pkg.
- halt  in  1  controller halt; freezes all datapath loads.
- prog_we  in  1  RAM write strobe, honoured only while halt=1.
- prog_addr  in  ADDR_W  program-load address.
- prog_data  in  DATA_W  program-load data.
- opcode  out  4  IR[7:4] to the controller.
- bus  out  DATA_W  current W-bus value (debug).
- pc  out  ADDR_W  program counter.
- out_data  out  DATA_W  output register.
- out_valid  out  1  one-cycle pulse when the output register loads.
- carry  out  1  ALU carry/borrow captured on accumulator load from the ALU.
- bus_err  out  1  sticky: two or more bus drivers enabled in one cycle.

Behaviour:
- cw bits (sap1_pkg):
  - 11 CP: PC increment
  - 10 EP: PC to bus
  - 9 LM: load MAR
  - 8 CE: RAM[MAR] to bus
  - 7 LI: load IR
  - 6 EI: IR[3:0] to bus
  - 5 LA: load A
  - 4 EA: A to bus
  - 3 SU: subtract select
  - 2 EU: ALU to bus
  - 1 LB: load B
  - 0 LO: load output
- Bus is combinational from the current cw.
  - Drivers: EP={0,PC}, CE=RAM[MAR], EI={0,IR[3:0]}, EA=A, EU=ALU.
  - No driver enabled: bus=0.
  - More than one driver enabled: bus = OR of the enabled sources, and bus_err is set on the next edge. bus_err clears only on reset.
- ALU is combinational, DATA_W+1 bits wide:
  - SU=0: A+B.
  - SU=1: A+~B+1.
  - Low DATA_W bits go to the bus; the MSB is the carry. For SU=1, carry=1 means no borrow.
  - Results wrap modulo 2**DATA_W.
- Loads are sampled at the rising edge from the bus value of that cycle. Every load has one-cycle latency.
  - Same-cycle EA+LA or EU+LA is legal: A takes the old-value-derived bus.
- carry updates only on a cycle with LA&EU.
- CP increments PC, wrapping 15 -> 0. CP and EP in the same cycle: bus carries the old PC and PC increments.
- out_valid=1 in the cycle after an LO edge, 0 otherwise.
- opcode = IR[7:4], registered through IR with no extra delay.
- halt=1:
  - All LM/LI/LA/LB/LO/CP effects are suppressed and bus_err is not updated.
  - The bus still reflects cw for debug.
  - prog_we writes prog_data to RAM[prog_addr] on the edge.
- prog_we with halt=0 is ignored.
- Reset (rst=0), asynchronous:
  - PC, MAR, IR, A, B, out_data and carry go to 0.
  - out_valid=0, bus_err=0, so opcode=0.
  - RAM contents are preserved, so a program survives reset.
  - Mid-instruction reset abandons all partial loads. On release the next edge is a normal edge.
- RAM has an asynchronous read and a synchronous write. Reading and writing the same address in one halted cycle returns the old data on the bus.

Decomposition:
- sap1_pkg holds:
  - CW_* bit-index constants.
  - the cw width (12).
  - opcode constants: LDA=0000, ADD=0001, SUB=0010, OUT=1110, HLT=1111.
  - shared with the controller.
- Sub-module sap1_alu: combinational add/sub with carry, DATA_W parameter. Registers, bus mux and RAM stay in sap1_datapath.

Test Plan:
- Reset:
  - Stimulus: preload RAM while halt=1, pulse rst=0 mid-cycle.
  - Required: pc=0, opcode=0, out_data=0, bus_err=0 immediately. RAM[9] is still 0x10 afterwards.
- Fetch:
  - Stimulus: halt=0, RAM[0]=0x09. Drive EP|LM, then CP, then CE|LI.
  - Required: MAR=0, pc=1, opcode=0000, IR=0x09 after the three edges.
- LDA/ADD/SUB/OUT program:
  - Stimulus: RAM 0:09 1:1A 2:2B 3:E0 4:F0, 9:10 A:14 B:04. Hand-drive the canonical T4-T6 words per opcode.
  - Required: A=0x10, then 0x24, then 0x20. out_data=0x20 with a single out_valid pulse, then opcode=1111.
- Wrap and carry:
  - Stimulus: A=0xF0, B=0x20, ADD.
  - Required: A=0x10, carry=1.
  - Stimulus: A=0x04, B=0x05, SUB.
  - Required: A=0xFF, carry=0.
  - Stimulus: PC at 15 with CP.
  - Required: pc=0.
- Halt behaviour:
  - Stimulus: halt=1 with cw=LA|EP, and prog_we to addr 5 data 0x77.
  - Required: A unchanged, RAM[5]=0x77.
  - Stimulus: halt=0 with prog_we to addr 6.
  - Required: RAM[6] unchanged.
- Contention:
  - Stimulus: cw=EP|EA with A=0x80, pc=3.
  - Required: bus=0x83, bus_err=1 next cycle, and it stays 1 until rst=0.
